// File: rtl/if_fetch_req.sv
// Instruction-fetch request unit: one SRAM-like read per fetch address,
// single outstanding transaction, flush-killed responses are swallowed.
module if_fetch_req #(
    parameter int          ADEL_BIT = 4,
    parameter logic [31:0] RESET_PC = 32'hbfbf_fffc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [64:0] pc_to_ic_bus,
    output logic        stallreq_if,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic [96:0] ic_to_id_bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP
    } state_t;

    localparam logic        STOP     = 1'b1;
    localparam logic [31:0] ADEL_VEC = 32'd1 << ADEL_BIT;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        flseen_q, flseen_d;
    logic [31:0] buf_q, buf_d;

    logic [31:0] exc_q, pc_q, inst_q;
    logic        valid_q;

    logic [31:0] exc_in, pc_in;
    logic        ce, misaligned, need;

    logic        req_c, sreq_c, deliver_c;
    logic [31:0] addr_c, dinst_c;

    logic        unused_stall;

    assign exc_in     = pc_to_ic_bus[64:33];
    assign ce         = pc_to_ic_bus[32];
    assign pc_in      = pc_to_ic_bus[31:0];
    assign misaligned = pc_in[1:0] != 2'b00;
    // A new fetch is never started in the cycle that flush retargets the pc.
    assign need       = ce & ~flush;
    assign unused_stall = ^{stall[5:3], stall[0]};

    // State, latched request address, flush-seen flag and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0;
            flseen_q <= 1'b0;
            buf_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            flseen_q <= flseen_d;
            buf_q    <= buf_d;
        end
    end

    // Next-state logic for the single-outstanding-read protocol.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        flseen_d = 1'b0;
        buf_d    = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (need && !misaligned) begin
                    addr_d  = pc_in;
                    state_d = inst_sram_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (inst_sram_addr_ok)
                    state_d = (flseen_q | flush) ? S_DROP : S_WAIT;
                else
                    flseen_d = flseen_q | flush;
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    buf_d   = inst_sram_rdata;
                    state_d = (stall[1] == STOP && !flush) ? S_HOLD : S_IDLE;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush || stall[1] != STOP)
                    state_d = S_IDLE;
            end
            S_DROP: begin
                if (inst_sram_data_ok)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request, IF stall request and the word offered to ID.
    always_comb begin
        req_c     = 1'b0;
        sreq_c    = 1'b0;
        deliver_c = 1'b0;
        addr_c    = pc_in;
        dinst_c   = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                if (need) begin
                    if (!misaligned) begin
                        req_c  = 1'b1;
                        sreq_c = 1'b1;
                    end else begin
                        deliver_c = 1'b1;
                    end
                end
            end
            S_REQ: begin
                req_c  = 1'b1;
                sreq_c = 1'b1;
                addr_c = addr_q;
            end
            S_WAIT: begin
                sreq_c    = ~inst_sram_data_ok;
                deliver_c = inst_sram_data_ok;
                dinst_c   = inst_sram_rdata;
            end
            S_HOLD: begin
                deliver_c = 1'b1;
                dinst_c   = buf_q;
            end
            S_DROP: sreq_c = 1'b1;
            default: sreq_c = 1'b0;
        endcase
    end

    // IF/ID output register: flush kills, stall from ID holds, else bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q   <= 32'h0;
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (stall[1] != STOP && deliver_c) begin
            exc_q   <= exc_in | (misaligned ? ADEL_VEC : 32'h0);
            valid_q <= 1'b1;
            pc_q    <= pc_in;
            inst_q  <= dinst_c;
        end else if (stall[1] == STOP && stall[2] != STOP) begin
            valid_q <= 1'b0;
        end
    end

    assign inst_sram_req   = req_c & ~rst;
    assign stallreq_if     = sreq_c & ~rst;
    assign inst_sram_addr  = addr_c;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign ic_to_id_bus    = {exc_q, valid_q, pc_q, inst_q};

endmodule
